// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, register writeback, flush and ID/EX
// outputs of the decode stage, bundled for connection between stage and environment.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      opcode;
   logic [1:0]      type_inst;
   logic [XLEN-1:0] Rs1_val;
   logic [XLEN-1:0] Rs2_val;
   logic [15:0]     imm;
   logic [25:0]     offset26;
   logic [4:0]      rd;

   // Decode stage view: consumes instructions and writebacks, produces ID/EX fields.
   modport slave (
      input  in_valid, instr, wb_en, wb_addr, wb_data, flush, out_ready,
      output in_ready, out_valid, opcode, type_inst, Rs1_val, Rs2_val, imm, offset26, rd
   );

   // Environment view: fetch/writeback/execute side of the stage.
   modport master (
      output in_valid, instr, wb_en, wb_addr, wb_data, flush, out_ready,
      input  in_ready, out_valid, opcode, type_inst, Rs1_val, Rs2_val, imm, offset26, rd
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: DLX instruction decode with a 32x32 register file (write-through
// bypass on reads) and a valid/ready ID/EX pipeline register with flush.
module decode_stage #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   decode_stage_if.slave bus
);

   localparam logic [1:0] TYPE_BUBBLE = 2'b00;
   localparam logic [1:0] TYPE_R      = 2'b01;
   localparam logic [1:0] TYPE_J      = 2'b10;
   localparam logic [1:0] TYPE_I      = 2'b11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQZ  = 6'h04;
   localparam logic [5:0] OP_BNEZ  = 6'h05;
   localparam logic [5:0] OP_JR    = 6'h12;
   localparam logic [5:0] OP_JALR  = 6'h13;

   // Register read with r0 hard-wired to zero and same-cycle writeback forwarding.
   function automatic logic [XLEN-1:0] bypass_read(
      input logic [4:0]      idx,
      input logic [XLEN-1:0] stored,
      input logic            wen,
      input logic [4:0]      waddr,
      input logic [XLEN-1:0] wdata
   );
      logic [XLEN-1:0] val;
      if (idx == 5'd0) begin
         val = '0;
      end else if (wen && (waddr == idx)) begin
         val = wdata;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   logic [XLEN-1:0] regs_r [NREGS];

   logic [5:0]      op_s;
   logic [1:0]      dec_type_s;
   logic [5:0]      dec_opcode_s;
   logic [4:0]      dec_rs1_s;
   logic [4:0]      dec_rs2_s;
   logic [4:0]      dec_rd_s;
   logic [15:0]     dec_imm_s;
   logic [25:0]     dec_off_s;
   logic [XLEN-1:0] rs1_val_s;
   logic [XLEN-1:0] rs2_val_s;
   logic            in_ready_s;
   logic            capture_s;

   logic            out_valid_r;
   logic [5:0]      opcode_r;
   logic [1:0]      type_r;
   logic [XLEN-1:0] rs1_val_r;
   logic [XLEN-1:0] rs2_val_r;
   logic [15:0]     imm_r;
   logic [25:0]     off_r;
   logic [4:0]      rd_r;

   assign op_s = bus.instr[31:26];

   // Field split by format; unused source indices stay 0 so their operands read as zero.
   always_comb begin
      dec_type_s   = TYPE_BUBBLE;
      dec_opcode_s = 6'd0;
      dec_rs1_s    = 5'd0;
      dec_rs2_s    = 5'd0;
      dec_rd_s     = 5'd0;
      dec_imm_s    = 16'd0;
      dec_off_s    = 26'd0;
      if (bus.instr == 32'h0000_0000) begin
         dec_type_s = TYPE_BUBBLE;
      end else begin
         case (op_s)
            OP_RTYPE: begin
               dec_type_s   = TYPE_R;
               dec_opcode_s = bus.instr[5:0];
               dec_rs1_s    = bus.instr[25:21];
               dec_rs2_s    = bus.instr[20:16];
               dec_rd_s     = bus.instr[15:11];
            end
            OP_J, OP_JAL: begin
               dec_type_s   = TYPE_J;
               dec_opcode_s = op_s;
               dec_off_s    = bus.instr[25:0];
               dec_rd_s     = (op_s == OP_JAL) ? 5'd31 : 5'd0;
            end
            default: begin
               dec_type_s   = TYPE_I;
               dec_opcode_s = op_s;
               dec_rs1_s    = bus.instr[25:21];
               dec_imm_s    = bus.instr[15:0];
               if ((op_s == OP_BEQZ) || (op_s == OP_BNEZ) || (op_s == OP_JR) || (op_s == OP_JALR)) begin
                  dec_rd_s = 5'd0;
               end else begin
                  dec_rd_s = bus.instr[20:16];
               end
            end
         endcase
      end
   end

   assign rs1_val_s = bypass_read(dec_rs1_s, regs_r[dec_rs1_s], bus.wb_en, bus.wb_addr, bus.wb_data);
   assign rs2_val_s = bypass_read(dec_rs2_s, regs_r[dec_rs2_s], bus.wb_en, bus.wb_addr, bus.wb_data);

   assign in_ready_s = !out_valid_r || bus.out_ready;
   assign capture_s  = bus.in_valid && in_ready_s;

   // Register file: cleared on reset, writes to r0 are discarded (flush does not block writes).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
         regs_r[bus.wb_addr] <= bus.wb_data;
      end
   end

   // ID/EX register: flush beats capture, capture loads all fields, consume only drops valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r <= 1'b0;
         opcode_r    <= 6'd0;
         type_r      <= TYPE_BUBBLE;
         rs1_val_r   <= '0;
         rs2_val_r   <= '0;
         imm_r       <= 16'd0;
         off_r       <= 26'd0;
         rd_r        <= 5'd0;
      end else if (bus.flush) begin
         out_valid_r <= 1'b0;
         type_r      <= TYPE_BUBBLE;
         rd_r        <= 5'd0;
      end else if (capture_s) begin
         out_valid_r <= 1'b1;
         opcode_r    <= dec_opcode_s;
         type_r      <= dec_type_s;
         rs1_val_r   <= rs1_val_s;
         rs2_val_r   <= rs2_val_s;
         imm_r       <= dec_imm_s;
         off_r       <= dec_off_s;
         rd_r        <= dec_rd_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.opcode    = opcode_r;
   assign bus.type_inst = type_r;
   assign bus.Rs1_val   = rs1_val_r;
   assign bus.Rs2_val   = rs2_val_r;
   assign bus.imm       = imm_r;
   assign bus.offset26  = off_r;
   assign bus.rd        = rd_r;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
module tb_decode_stage;
   logic clk;
   logic reset_n;
   int   vectors     = 0;
   int   miscompares = 0;

   decode_stage_if #(.XLEN(32)) bus ();

   decode_stage #(.NREGS(32), .XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.instr     = 32'h0;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = 5'd0;
      bus.wb_data   = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      #7;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.type_inst !== 2'b00) begin miscompares++; $display("FAIL reset_type: got %b expected 00", bus.type_inst); end
      vectors++; if (bus.rd !== 5'd0) begin miscompares++; $display("FAIL reset_rd: got %0d expected 0", bus.rd); end
      vectors++; if (bus.opcode !== 6'd0) begin miscompares++; $display("FAIL reset_opcode: got %h expected 00", bus.opcode); end
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL reset_rs1: got %h expected 0", bus.Rs1_val); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      reset_n = 1'b1;
   endtask

   task automatic test_rtype();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_0007;
      step();
      bus.wb_addr = 5'd6; bus.wb_data = 32'hFFFF_FFFD;
      step();
      bus.wb_en = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h00A6_3820;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL r_valid: got %b expected 1", bus.out_valid); end
      vectors++; if (bus.type_inst !== 2'b01) begin miscompares++; $display("FAIL r_type: got %b expected 01", bus.type_inst); end
      vectors++; if (bus.opcode !== 6'h20) begin miscompares++; $display("FAIL r_opcode: got %h expected 20", bus.opcode); end
      vectors++; if (bus.Rs1_val !== 32'h0000_0007) begin miscompares++; $display("FAIL r_rs1: got %h expected 00000007", bus.Rs1_val); end
      vectors++; if (bus.Rs2_val !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL r_rs2: got %h expected fffffffd", bus.Rs2_val); end
      vectors++; if (bus.rd !== 5'd7) begin miscompares++; $display("FAIL r_rd: got %0d expected 7", bus.rd); end
      vectors++; if (bus.imm !== 16'h0) begin miscompares++; $display("FAIL r_imm: got %h expected 0000", bus.imm); end
      step();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL r_drain_valid: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.rd !== 5'd7) begin miscompares++; $display("FAIL r_hold_rd: got %0d expected 7", bus.rd); end
   endtask

   task automatic test_itype();
      bus.in_valid = 1'b1; bus.instr = 32'h20A3_FFF0;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.type_inst !== 2'b11) begin miscompares++; $display("FAIL i_type: got %b expected 11", bus.type_inst); end
      vectors++; if (bus.opcode !== 6'h08) begin miscompares++; $display("FAIL i_opcode: got %h expected 08", bus.opcode); end
      vectors++; if (bus.Rs1_val !== 32'h0000_0007) begin miscompares++; $display("FAIL i_rs1: got %h expected 00000007", bus.Rs1_val); end
      vectors++; if (bus.Rs2_val !== 32'h0) begin miscompares++; $display("FAIL i_rs2: got %h expected 0", bus.Rs2_val); end
      vectors++; if (bus.imm !== 16'hFFF0) begin miscompares++; $display("FAIL i_imm: got %h expected fff0", bus.imm); end
      vectors++; if (bus.rd !== 5'd3) begin miscompares++; $display("FAIL i_rd: got %0d expected 3", bus.rd); end
      step();
   endtask

   task automatic test_bypass();
      bus.in_valid = 1'b1; bus.instr = 32'h20A3_FFF0;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_0055;
      step();
      bus.wb_en = 1'b0;
      vectors++; if (bus.Rs1_val !== 32'h0000_0055) begin miscompares++; $display("FAIL bypass_rs1: got %h expected 00000055", bus.Rs1_val); end
      bus.instr = 32'h10A6_0005;
      step();
      vectors++; if (bus.Rs1_val !== 32'h0000_0055) begin miscompares++; $display("FAIL branch_rs1: got %h expected 00000055", bus.Rs1_val); end
      vectors++; if (bus.rd !== 5'd0) begin miscompares++; $display("FAIL branch_rd: got %0d expected 0", bus.rd); end
      vectors++; if (bus.opcode !== 6'h04) begin miscompares++; $display("FAIL branch_opcode: got %h expected 04", bus.opcode); end
      vectors++; if (bus.imm !== 16'h0005) begin miscompares++; $display("FAIL branch_imm: got %h expected 0005", bus.imm); end
      bus.instr = 32'h2003_0001;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_0099;
      step();
      bus.wb_en = 1'b0;
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL r0_bypass: got %h expected 0", bus.Rs1_val); end
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL r0_read: got %h expected 0", bus.Rs1_val); end
      vectors++; if (bus.rd !== 5'd3) begin miscompares++; $display("FAIL r0_rd: got %0d expected 3", bus.rd); end
      step();
   endtask

   task automatic test_bubble_and_jump();
      bus.in_valid = 1'b1; bus.instr = 32'h0000_0000;
      step();
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bubble_valid: got %b expected 1", bus.out_valid); end
      vectors++; if (bus.type_inst !== 2'b00) begin miscompares++; $display("FAIL bubble_type: got %b expected 00", bus.type_inst); end
      vectors++; if (bus.opcode !== 6'h00) begin miscompares++; $display("FAIL bubble_opcode: got %h expected 00", bus.opcode); end
      bus.instr = 32'h08A0_0020;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.type_inst !== 2'b10) begin miscompares++; $display("FAIL j_type: got %b expected 10", bus.type_inst); end
      vectors++; if (bus.opcode !== 6'h02) begin miscompares++; $display("FAIL j_opcode: got %h expected 02", bus.opcode); end
      vectors++; if (bus.offset26 !== 26'h0A0_0020) begin miscompares++; $display("FAIL j_offset: got %h expected 0a00020", bus.offset26); end
      vectors++; if (bus.rd !== 5'd0) begin miscompares++; $display("FAIL j_rd: got %0d expected 0", bus.rd); end
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL j_rs1: got %h expected 0", bus.Rs1_val); end
      step();
   endtask

   task automatic test_stall();
      logic [31:0] stall_ins [3] = '{32'h0800_0001, 32'h20A3_FFF0, 32'h0000_0000};
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h00A6_3820;
      step();
      for (int i = 0; i < 3; i++) begin
         bus.instr = stall_ins[i];
         step();
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
         vectors++; if (bus.opcode !== 6'h20) begin miscompares++; $display("FAIL stall_opcode[%0d]: got %h expected 20", i, bus.opcode); end
         vectors++; if (bus.rd !== 5'd7) begin miscompares++; $display("FAIL stall_rd[%0d]: got %0d expected 7", i, bus.rd); end
         vectors++; if (bus.Rs1_val !== 32'h0000_0055) begin miscompares++; $display("FAIL stall_rs1[%0d]: got %h expected 00000055", i, bus.Rs1_val); end
      end
      bus.instr = 32'h20C4_000A;
      bus.out_ready = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.opcode !== 6'h08) begin miscompares++; $display("FAIL release_opcode: got %h expected 08", bus.opcode); end
      vectors++; if (bus.rd !== 5'd4) begin miscompares++; $display("FAIL release_rd: got %0d expected 4", bus.rd); end
      vectors++; if (bus.Rs1_val !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL release_rs1: got %h expected fffffffd", bus.Rs1_val); end
      vectors++; if (bus.imm !== 16'h000A) begin miscompares++; $display("FAIL release_imm: got %h expected 000a", bus.imm); end
      step();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_no_dup: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [3] = '{32'h20A3_FFF0, 32'h08A0_0020, 32'h00A6_3820};
      logic [4:0]  rds [3] = '{5'd3, 5'd0, 5'd7};
      logic [5:0]  ops [3] = '{6'h08, 6'h02, 6'h20};
      logic [1:0]  tys [3] = '{2'b11, 2'b10, 2'b01};
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.instr = ins[i];
         step();
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         vectors++; if (bus.rd !== rds[i]) begin miscompares++; $display("FAIL b2b_rd[%0d]: got %0d expected %0d", i, bus.rd, rds[i]); end
         vectors++; if (bus.opcode !== ops[i]) begin miscompares++; $display("FAIL b2b_opcode[%0d]: got %h expected %h", i, bus.opcode, ops[i]); end
         vectors++; if (bus.type_inst !== tys[i]) begin miscompares++; $display("FAIL b2b_type[%0d]: got %b expected %b", i, bus.type_inst, tys[i]); end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_jal_flush();
      bus.in_valid = 1'b1; bus.instr = 32'h0C00_0010;
      step();
      vectors++; if (bus.type_inst !== 2'b10) begin miscompares++; $display("FAIL jal_type: got %b expected 10", bus.type_inst); end
      vectors++; if (bus.opcode !== 6'h03) begin miscompares++; $display("FAIL jal_opcode: got %h expected 03", bus.opcode); end
      vectors++; if (bus.offset26 !== 26'h000_0010) begin miscompares++; $display("FAIL jal_offset: got %h expected 0000010", bus.offset26); end
      vectors++; if (bus.rd !== 5'd31) begin miscompares++; $display("FAIL jal_rd: got %0d expected 31", bus.rd); end
      bus.instr = 32'h20A3_FFF0; bus.flush = 1'b1;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h0000_1234;
      step();
      bus.flush = 1'b0; bus.wb_en = 1'b0; bus.in_valid = 1'b0;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.type_inst !== 2'b00) begin miscompares++; $display("FAIL flush_type: got %b expected 00", bus.type_inst); end
      vectors++; if (bus.rd !== 5'd0) begin miscompares++; $display("FAIL flush_rd: got %0d expected 0", bus.rd); end
      step();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: got %b expected 0", bus.out_valid); end
      bus.in_valid = 1'b1; bus.instr = 32'h2121_0000;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.Rs1_val !== 32'h0000_1234) begin miscompares++; $display("FAIL flush_wb: got %h expected 00001234", bus.Rs1_val); end
      vectors++; if (bus.rd !== 5'd1) begin miscompares++; $display("FAIL flush_wb_rd: got %0d expected 1", bus.rd); end
      step();
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.instr = 32'h00A6_3820;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid: got %b expected 1", bus.out_valid); end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.opcode !== 6'h00) begin miscompares++; $display("FAIL arst_opcode: got %h expected 00", bus.opcode); end
      vectors++; if (bus.rd !== 5'd0) begin miscompares++; $display("FAIL arst_rd: got %0d expected 0", bus.rd); end
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL arst_rs1: got %h expected 0", bus.Rs1_val); end
      vectors++; if (bus.Rs2_val !== 32'h0) begin miscompares++; $display("FAIL arst_rs2: got %h expected 0", bus.Rs2_val); end
      vectors++; if (bus.type_inst !== 2'b00) begin miscompares++; $display("FAIL arst_type: got %b expected 00", bus.type_inst); end
      #2;
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
      bus.in_valid = 1'b1; bus.instr = 32'h00A6_3820;
      step();
      bus.in_valid = 1'b0;
      vectors++; if (bus.Rs1_val !== 32'h0) begin miscompares++; $display("FAIL arst_rf_rs1: got %h expected 0", bus.Rs1_val); end
      vectors++; if (bus.Rs2_val !== 32'h0) begin miscompares++; $display("FAIL arst_rf_rs2: got %h expected 0", bus.Rs2_val); end
      vectors++; if (bus.rd !== 5'd7) begin miscompares++; $display("FAIL arst_rf_rd: got %0d expected 7", bus.rd); end
      step();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_bypass();
      test_bubble_and_jump();
      test_stall();
      test_back_to_back();
      test_jal_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage sitting directly upstream of the execute ALU.
- Accepts 32-bit DLX-format instruction words from fetch and splits fields by format (R/I/J).
- Reads a 32x32 register file that includes a writeback port, and latches opcode, operand values, immediate, type_inst and destination into an ID/EX pipeline register.
- Handshake is valid/ready on both sides, plus a flush for taken branches.

Parameters:
- NREGS, 32, number of architectural registers. r0 always reads zero.
- XLEN, 32, register and operand width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr holds a valid instruction
- in_ready  out  1  stage can accept instr this cycle
- instr  in  32  instruction word
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  XLEN  write data
- flush  in  1  discard the held and incoming instruction
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute consumes the output this cycle
- opcode  out  6  ALU opcode (func field for R, primary opcode for I/J)
- type_inst  out  2  01=R, 11=I, 10=J, 00=bubble
- Rs1_val  out  XLEN  signed operand 1
- Rs2_val  out  XLEN  signed operand 2 (0 for I/J)
- imm  out  16  signed immediate
- offset26  out  26  jump offset (J only, else 0)
- rd  out  5  destination index (0 = no write)

Behaviour:
- Reset (async, reset_n=0):
  - all ID/EX outputs = 0, out_valid=0, type_inst=00.
  - All register-file entries = 0.
- Decode fields from instr:
  - op = instr[31:26]
  - R-type (op=0x00): rs1=[25:21], rs2=[20:16], rd=[15:11], opcode=[5:0], type=01, imm=0.
  - J-type (op=0x02 j, 0x03 jal): type=10, opcode=op, offset26=[25:0], imm=0. rd=31 for jal, 0 for j. Rs1_val=Rs2_val=0.
  - instr=0x00000000 (R-type with func=0): type=00 bubble, all fields 0. It still occupies a slot with out_valid=1.
  - All other op values: I-type, type=11, opcode=op, rs1=[25:21], rd=[20:16], imm=[15:0], Rs2_val=0.
  - Branches 0x04/0x05 and jr/jalr 0x12/0x13 force rd=0.
- Register file:
  - Write on clk rise when wb_en=1 and wb_addr!=0. Writes to r0 are ignored.
  - Reads are combinational, with write-through bypass: if wb_en && wb_addr==rsX && wb_addr!=0, Rs*_val takes wb_data in the same cycle.
  - r0 always reads 0.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
  - Capture on clk rise when in_valid && in_ready: the ID/EX register loads the decoded fields and out_valid=1.
  - If out_ready=1 and no new capture: out_valid=0 next cycle; fields hold their last values.
  - If out_valid=1 and out_ready=0 (stall): all outputs are held stable; in_ready=0.
  - Latency is 1 cycle from instr capture to outputs.
- Flush:
  - Synchronous, and it overrides capture: next cycle out_valid=0, type_inst=00, rd=0.
  - The instruction presented on the flush cycle is dropped.
  - The register-file write in the same cycle still happens.
- Simultaneous consume and capture: back-to-back throughput of 1 instr/cycle with no bubble.
- Reset mid-stall: outputs clear immediately (asynchronous). in_ready=1 once reset_n deasserts.
- Widths:
  - imm is carried as a raw 16-bit value; sign extension is done by the consumer.
  - Rs values are full XLEN with no truncation.

Test Plan:
- Reset then write r5=0x00000007 and r6=0xFFFFFFFD via wb. Send R add instr 0x00A63820 (rs1=5, rs2=6, rd=7, func=0x20) -> next cycle out_valid=1, type=01, opcode=0x20, Rs1_val=7, Rs2_val=-3, rd=7.
- I-type addi 0x20A3FFF0 (op=0x08, rs1=5, rd=3, imm=0xFFF0) -> type=11, opcode=0x08, Rs1_val=7, Rs2_val=0, imm=0xFFF0, rd=3.
- Bypass and r0 handling:
  - wb_en=1, wb_addr=5, wb_data=0x55 in the same cycle as a read of r5 -> Rs1_val=0x55.
  - wb_addr=0, wb_data=0x99, then a read of r0 -> Rs1_val=0.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 and changing instr -> outputs unchanged and in_ready=0 throughout. Raise out_ready -> next instr captured in the following cycle; no instruction is lost or duplicated.
- jal 0x0C000010 -> type=10, opcode=0x03, offset26=0x0000010, rd=31. Assert flush on the following capture cycle -> out_valid=0, type=00, and the flushed instr never appears.
- Assert reset_n=0 asynchronously between clock edges while out_valid=1 -> out_valid and all outputs go to 0 immediately, and register-file reads return 0 after release.
